// File: rtl/branch_pred_pkg.sv
// Shared types for the branch prediction pipeline.
//   bp_info_t : prediction record {valid, pc, pred_taken, pred_target}
//   PC_STEP   : fall-through increment used for not-taken redirects
package branch_pred_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } bp_info_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_resolver_if.sv
// Pipeline-side bundle of branch_resolver.
//   Fetch     : valid_F, PC_F, hit_F, target_F
//   Control   : stall_D, stall_E, flush_D, flush_E
//   Execute   : branch_E, taken_E, target_actual_E
//   BTB write : update_en, PC_upd, target_upd
//   Redirect  : redirect_E, redirect_PC_E
// master = the pipeline driving Fetch/Execute; slave = the resolver.
interface branch_resolver_if;

    logic        valid_F;
    logic [31:0] PC_F;
    logic        hit_F;
    logic [31:0] target_F;
    logic        stall_D;
    logic        stall_E;
    logic        flush_D;
    logic        flush_E;
    logic        branch_E;
    logic        taken_E;
    logic [31:0] target_actual_E;
    logic        update_en;
    logic [31:0] PC_upd;
    logic [31:0] target_upd;
    logic        redirect_E;
    logic [31:0] redirect_PC_E;

    modport master (
        output valid_F, PC_F, hit_F, target_F,
        output stall_D, stall_E, flush_D, flush_E,
        output branch_E, taken_E, target_actual_E,
        input  update_en, PC_upd, target_upd, redirect_E, redirect_PC_E
    );

    modport slave (
        input  valid_F, PC_F, hit_F, target_F,
        input  stall_D, stall_E, flush_D, flush_E,
        input  branch_E, taken_E, target_actual_E,
        output update_en, PC_upd, target_upd, redirect_E, redirect_PC_E
    );

endinterface

// File: rtl/bp_pipe_reg.sv
// One prediction pipeline register (used for F/D and D/E).
// Update priority per edge: rst > invalidate > hold > advance.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   inval_i   : clear valid (other fields keep their old value, don't-care)
//   hold_i    : keep current contents
//   d_i       : record to capture when advancing
//   q_o       : registered record
module bp_pipe_reg
    import branch_pred_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     inval_i,
    input  logic     hold_i,
    input  bp_info_t d_i,
    output bp_info_t q_o
);

    bp_info_t info_q, info_d;

    always_comb begin
        info_d = info_q;
        if (inval_i) begin
            info_d.valid = 1'b0;
        end else if (!hold_i) begin
            info_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) info_q <= '0;
        else     info_q <= info_d;
    end

    assign q_o = info_q;

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver. Carries each fetched instruction's BTB
// prediction through F/D and D/E, compares it against the resolved outcome
// in Execute, and drives the BTB write port and the fetch redirect. A
// redirect also invalidates both prediction registers (wrong-path squash).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : fetch/control/execute inputs, BTB write + redirect outputs
//   branch_count      : resolved branches, saturating   (BP_STATS_EN only)
//   mispredict_count  : redirects issued, saturating    (BP_STATS_EN only)
// Optional feature macro: BP_STATS_EN enables the two statistics counters.
module branch_resolver
    import branch_pred_pkg::*;
#(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolver_if.slave      bus
`ifdef BP_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
`endif
);

    bp_info_t fd_in, fd, de;
    logic     resolve;
    logic     taken_miss;  // taken branch with missing or wrong target
    logic     fall_miss;   // predicted taken but execution falls through
    logic     redirect;

    assign fd_in = '{valid:       bus.valid_F,
                     pc:          bus.PC_F,
                     pred_taken:  bus.hit_F,
                     pred_target: bus.target_F};

    bp_pipe_reg u_fd (
        .clk     (clk),
        .rst     (rst),
        .inval_i (bus.flush_D | redirect),
        .hold_i  (bus.stall_D),
        .d_i     (fd_in),
        .q_o     (fd)
    );

    bp_pipe_reg u_de (
        .clk     (clk),
        .rst     (rst),
        .inval_i (bus.flush_E | redirect),
        .hold_i  (bus.stall_E),
        .d_i     (fd),
        .q_o     (de)
    );

    // A stalled Execute is not completing, so nothing resolves.
    assign resolve    = de.valid & ~bus.stall_E;
    assign taken_miss = bus.branch_E & bus.taken_E &
                        (~de.pred_taken | (de.pred_target != bus.target_actual_E));
    assign fall_miss  = de.pred_taken & ~(bus.branch_E & bus.taken_E);
    assign redirect   = resolve & (taken_miss | fall_miss);

    always_comb begin
        bus.redirect_E    = redirect;
        bus.redirect_PC_E = '0;
        bus.update_en     = resolve & taken_miss;
        bus.PC_upd        = '0;
        bus.target_upd    = '0;
        if (redirect) begin
            bus.redirect_PC_E = taken_miss ? bus.target_actual_E : de.pc + PC_STEP;
        end
        if (resolve) begin
            bus.PC_upd     = de.pc;
            bus.target_upd = bus.target_actual_E;
        end
    end

`ifdef BP_STATS_EN
    logic [STAT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [STAT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (resolve && bus.branch_E && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
        if (redirect && (mp_cnt_q != '1))                 mp_cnt_d = mp_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed cases followed by random
// traffic, checked against an instruction-level reference model.
module tb_branch_resolver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolver_if bus ();

`ifdef BP_STATS_EN
    logic [31:0] branch_count, mispredict_count;
`endif

    branch_resolver #(.STAT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BP_STATS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    typedef struct packed {
        logic        rst;
        logic        valid_F;
        logic [31:0] PC_F;
        logic        hit_F;
        logic [31:0] target_F;
        logic        stall_D, stall_E, flush_D, flush_E;
        logic        branch_E, taken_E;
        logic [31:0] act;
    } stim_t;

    // An in-flight instruction as the model sees it.
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
    } inst_t;

    typedef struct packed {
        logic        resolve;
        logic        redir;
        logic [31:0] rpc;
        logic        upd;
        logic [31:0] pcu;
        logic [31:0] tgu;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    inst_t m_fd, m_de;
    logic [31:0] m_bc, m_mc;

    // Outcome of resolving one instruction, straight from the mispredict table.
    function automatic exp_t judge(inst_t i, stim_t s);
        exp_t e;
        e = '0;
        e.bc = m_bc;
        e.mc = m_mc;
        if (!i.v || s.stall_E) return e;
        e.resolve = 1'b1;
        e.pcu     = i.pc;
        e.tgu     = s.act;
        if (s.branch_E && s.taken_E) begin
            if (!i.hit || i.tgt != s.act) begin
                e.redir = 1'b1;
                e.rpc   = s.act;
                e.upd   = 1'b1;
            end
        end else if (i.hit) begin
            e.redir = 1'b1;
            e.rpc   = i.pc + 32'd4;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        rst                 = s.rst;
        bus.valid_F         = s.valid_F;
        bus.PC_F            = s.PC_F;
        bus.hit_F           = s.hit_F;
        bus.target_F        = s.target_F;
        bus.stall_D         = s.stall_D;
        bus.stall_E         = s.stall_E;
        bus.flush_D         = s.flush_D;
        bus.flush_E         = s.flush_E;
        bus.branch_E        = s.branch_E;
        bus.taken_E         = s.taken_E;
        bus.target_actual_E = s.act;
    endtask

    // Drive one cycle, queue what the DUT must show, then advance the model.
    task automatic cycle(input stim_t s, input bit check);
        exp_t  e;
        inst_t nf;
        drive(s);
        e = judge(m_de, s);
        if (check) sb_q.push_back(e);
        @(posedge clk);
        nf = '{v: s.valid_F, pc: s.PC_F, hit: s.hit_F, tgt: s.target_F};
        if (s.rst) begin
            m_fd = '0; m_de = '0; m_bc = '0; m_mc = '0;
        end else begin
            if (s.flush_E || e.redir) m_de.v = 1'b0;
            else if (!s.stall_E)      m_de = m_fd;
            if (s.flush_D || e.redir) m_fd.v = 1'b0;
            else if (!s.stall_D)      m_fd = nf;
            if (e.resolve && s.branch_E && m_bc != '1) m_bc++;
            if (e.redir && m_mc != '1)                 m_mc++;
        end
        #1;
    endtask

    // Monitor: outputs are combinational, so sample mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("redirect_E", {31'd0, bus.redirect_E}, {31'd0, e.redir});
            chk("update_en",  {31'd0, bus.update_en},  {31'd0, e.upd});
            if (e.redir || !e.resolve) chk("redirect_PC_E", bus.redirect_PC_E, e.rpc);
            if (e.upd || !e.resolve) begin
                chk("PC_upd",     bus.PC_upd,     e.pcu);
                chk("target_upd", bus.target_upd, e.tgu);
            end
`ifdef BP_STATS_EN
            chk("branch_count",     branch_count,     e.bc);
            chk("mispredict_count", mispredict_count, e.mc);
`endif
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        stim_t s;
        s = '0;
        s.valid_F = 1'b1; s.PC_F = pc; s.hit_F = hit; s.target_F = tgt;
        return s;
    endfunction

    function automatic stim_t exec(input logic br, input logic tk, input logic [31:0] act);
        stim_t s;
        s = '0;
        s.branch_E = br; s.taken_E = tk; s.act = act;
        return s;
    endfunction

    logic [31:0] pcs [6] = '{32'h100, 32'h40, 32'h1FC, 32'h200, 32'hFFFF_FFFC, 32'h80};

    initial begin
        stim_t s;
        m_fd = '0; m_de = '0; m_bc = '0; m_mc = '0;
        s = idle();
        s.rst = 1'b1;
        cycle(s, 1'b0);
        cycle(s, 1'b0);
        cycle(idle(), 1'b1);                       // reset state

        // Correct taken prediction
        cycle(fetch(32'h100, 1'b1, 32'h200), 1'b1);
        cycle(idle(), 1'b1);
        cycle(exec(1'b1, 1'b1, 32'h200), 1'b1);
        cycle(idle(), 1'b1);

        // Cold taken branch, then a squashed follower must stay silent
        cycle(fetch(32'h40, 1'b0, 32'h0), 1'b1);
        cycle(fetch(32'h44, 1'b1, 32'h999), 1'b1);
        cycle(exec(1'b1, 1'b1, 32'h80), 1'b1);
        cycle(exec(1'b0, 1'b0, 32'h0), 1'b1);
        cycle(exec(1'b0, 1'b0, 32'h0), 1'b1);

        // Wrong direction
        cycle(fetch(32'h1FC, 1'b1, 32'h300), 1'b1);
        cycle(idle(), 1'b1);
        cycle(exec(1'b1, 1'b0, 32'h0), 1'b1);

        // Stall then resolve: one redirect after the stall drops
        cycle(fetch(32'h40, 1'b0, 32'h0), 1'b1);
        cycle(idle(), 1'b1);
        s = exec(1'b1, 1'b1, 32'h80);
        s.stall_E = 1'b1;
        cycle(s, 1'b1);
        cycle(s, 1'b1);
        s.stall_E = 1'b0;
        cycle(s, 1'b1);
        cycle(s, 1'b1);

        // flush_E beats stall_E
        cycle(fetch(32'h300, 1'b1, 32'h500), 1'b1);
        cycle(idle(), 1'b1);
        s = idle();
        s.flush_E = 1'b1; s.stall_E = 1'b1;
        cycle(s, 1'b1);
        cycle(exec(1'b1, 1'b1, 32'h700), 1'b1);

        // Non-branch predicted taken at the top of memory wraps to 0
        cycle(fetch(32'hFFFF_FFFC, 1'b1, 32'h10), 1'b1);
        cycle(idle(), 1'b1);
        cycle(exec(1'b0, 1'b0, 32'h0), 1'b1);

        // Reset with FD and DE both valid, overriding stall/flush
        cycle(fetch(32'h100, 1'b0, 32'h0), 1'b1);
        cycle(fetch(32'h104, 1'b1, 32'h20), 1'b1);
        s = exec(1'b1, 1'b1, 32'h100);
        s.rst = 1'b1; s.stall_D = 1'b1; s.flush_E = 1'b1; s.stall_E = 1'b1;
        cycle(s, 1'b0);
        cycle(exec(1'b1, 1'b1, 32'h123), 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            s = '0;
            s.rst      = ($urandom_range(0, 99) == 0);
            s.valid_F  = ($urandom_range(0, 3) != 0);
            s.PC_F     = pcs[$urandom_range(0, 5)];
            s.hit_F    = $urandom_range(0, 1);
            s.target_F = pcs[$urandom_range(0, 5)];
            s.stall_D  = ($urandom_range(0, 4) == 0);
            s.stall_E  = ($urandom_range(0, 4) == 0);
            s.flush_D  = ($urandom_range(0, 9) == 0);
            s.flush_E  = ($urandom_range(0, 9) == 0);
            s.branch_E = $urandom_range(0, 1);
            s.taken_E  = $urandom_range(0, 1);
            s.act      = $urandom_range(0, 1) ? m_de.tgt : pcs[$urandom_range(0, 5)];
            cycle(s, 1'b1);
        end

        cycle(idle(), 1'b0);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
